// File: rtl/reg_rename_file.sv
// Architectural register file with per-register rename tags.
// Issue renames a destination to a ROB slot; in-order commit writes the value
// and retires the rename only if the register still points at that slot.
// Two combinational read ports serve the decoder, including a bypass of the
// commit happening in the same cycle.
//
// Handshake note: issue_enable and commit_enable are single-cycle qualifiers
// for their payloads. There is no backpressure. They take effect only on an
// edge where rdy is high. A low rdy freezes all state and drops the request.
module reg_rename_file #(
  parameter int REG_NUM   = 32,
  parameter int REG_POS_W = 5,
  parameter int ROB_POS_W = 4,
  parameter int DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 issue_enable,
  input  logic [REG_POS_W-1:0] issue_rd,
  input  logic [ROB_POS_W-1:0] issue_rob_pos,
  input  logic                 commit_enable,
  input  logic [REG_POS_W-1:0] commit_reg_pos,
  input  logic [DATA_W-1:0]    commit_val,
  input  logic [ROB_POS_W-1:0] commit_rob_pos,
  input  logic [REG_POS_W-1:0] rs1_pos,
  input  logic [REG_POS_W-1:0] rs2_pos,
  output logic                 rs1_busy,
  output logic [ROB_POS_W-1:0] rs1_rob_pos,
  output logic [DATA_W-1:0]    rs1_val,
  output logic                 rs2_busy,
  output logic [ROB_POS_W-1:0] rs2_rob_pos,
  output logic [DATA_W-1:0]    rs2_val
);

  logic [DATA_W-1:0]    val_q [REG_NUM];
  logic [DATA_W-1:0]    val_d [REG_NUM];
  logic [ROB_POS_W-1:0] tag_q [REG_NUM];
  logic [ROB_POS_W-1:0] tag_d [REG_NUM];
  logic [REG_NUM-1:0]   busy_q;
  logic [REG_NUM-1:0]   busy_d;

  logic issue_fire;
  logic commit_fire;

  // An issue during rollback belongs to the squashed path and is dropped.
  // x0 is never written, so its entry stays at the reset value of zero.
  assign issue_fire  = issue_enable && (issue_rd != '0) && !rollback;
  assign commit_fire = commit_enable && (commit_reg_pos != '0);

  // Next-state: commit writes value and retires a matching rename; a
  // same-cycle issue to the same register keeps it busy with the new tag.
  always_comb begin
    val_d  = val_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (rdy) begin
      if (commit_fire) begin
        val_d[commit_reg_pos] = commit_val;
        if ((tag_q[commit_reg_pos] == commit_rob_pos) &&
            !(issue_fire && (issue_rd == commit_reg_pos))) begin
          busy_d[commit_reg_pos] = 1'b0;
        end
      end
      if (rollback) begin
        busy_d = '0;
      end else if (issue_fire) begin
        busy_d[issue_rd] = 1'b1;
        tag_d[issue_rd]  = issue_rob_pos;
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      val_q  <= val_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
    end
  end

  // Read port 1: x0 is constant zero; a retiring producer is bypassed.
  always_comb begin
    rs1_busy    = busy_q[rs1_pos];
    rs1_rob_pos = tag_q[rs1_pos];
    rs1_val     = val_q[rs1_pos];
    if (rs1_pos == '0) begin
      rs1_busy    = 1'b0;
      rs1_rob_pos = '0;
      rs1_val     = '0;
    end else if (commit_enable && (commit_reg_pos == rs1_pos) &&
                 busy_q[rs1_pos] && (tag_q[rs1_pos] == commit_rob_pos)) begin
      rs1_busy    = 1'b0;
      rs1_rob_pos = '0;
      rs1_val     = commit_val;
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    rs2_busy    = busy_q[rs2_pos];
    rs2_rob_pos = tag_q[rs2_pos];
    rs2_val     = val_q[rs2_pos];
    if (rs2_pos == '0) begin
      rs2_busy    = 1'b0;
      rs2_rob_pos = '0;
      rs2_val     = '0;
    end else if (commit_enable && (commit_reg_pos == rs2_pos) &&
                 busy_q[rs2_pos] && (tag_q[rs2_pos] == commit_rob_pos)) begin
      rs2_busy    = 1'b0;
      rs2_rob_pos = '0;
      rs2_val     = commit_val;
    end
  end

endmodule

// File: tb/tb_reg_rename_file.sv
// Bench for reg_rename_file: directed scenarios followed by random traffic,
// all read ports compared against a register-array reference model.
module tb_reg_rename_file;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rdy, rollback;
  logic        issue_enable;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_rob_pos;
  logic        commit_enable;
  logic [4:0]  commit_reg_pos;
  logic [31:0] commit_val;
  logic [3:0]  commit_rob_pos;
  logic [4:0]  rs1_pos, rs2_pos;
  logic        rs1_busy, rs2_busy;
  logic [3:0]  rs1_rob_pos, rs2_rob_pos;
  logic [31:0] rs1_val, rs2_val;

  reg_rename_file dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .issue_enable(issue_enable), .issue_rd(issue_rd), .issue_rob_pos(issue_rob_pos),
    .commit_enable(commit_enable), .commit_reg_pos(commit_reg_pos),
    .commit_val(commit_val), .commit_rob_pos(commit_rob_pos),
    .rs1_pos(rs1_pos), .rs2_pos(rs2_pos),
    .rs1_busy(rs1_busy), .rs1_rob_pos(rs1_rob_pos), .rs1_val(rs1_val),
    .rs2_busy(rs2_busy), .rs2_rob_pos(rs2_rob_pos), .rs2_val(rs2_val)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_val  [32];
  logic        m_busy [32];
  logic [3:0]  m_tag  [32];
  logic [31:0] n_val  [32];
  logic        n_busy [32];
  logic [3:0]  n_tag  [32];

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
    end
  endtask

  // Compute next register state from the current inputs (applied after the edge).
  task automatic model_next();
    for (int i = 0; i < 32; i++) begin
      n_val[i] = m_val[i]; n_busy[i] = m_busy[i]; n_tag[i] = m_tag[i];
    end
    if (rdy) begin
      if (commit_enable && commit_reg_pos != 0) begin
        n_val[commit_reg_pos] = commit_val;
        if (m_tag[commit_reg_pos] == commit_rob_pos &&
            !(issue_enable && !rollback && issue_rd == commit_reg_pos))
          n_busy[commit_reg_pos] = 1'b0;
      end
      if (rollback) begin
        for (int i = 0; i < 32; i++) n_busy[i] = 1'b0;
      end else if (issue_enable && issue_rd != 0) begin
        n_busy[issue_rd] = 1'b1;
        n_tag[issue_rd]  = issue_rob_pos;
      end
    end
  endtask

  // Check one read port: expected values queued, then drained in order.
  task automatic check_port(input string nm, input logic [4:0] pos, input logic obusy,
                            input logic [3:0] orob, input logic [31:0] oval);
    logic eb; logic [3:0] er; logic [31:0] ev; logic rob_known;
    logic [31:0] e;
    if (pos == 0) begin
      eb = 0; er = 0; ev = 0; rob_known = 1;
    end else if (commit_enable && commit_reg_pos == pos && m_busy[pos] &&
                 m_tag[pos] == commit_rob_pos) begin
      eb = 0; er = 0; ev = commit_val; rob_known = 1;
    end else begin
      eb = m_busy[pos]; er = m_tag[pos]; ev = m_val[pos]; rob_known = m_busy[pos];
    end
    exp_q.push_back({31'd0, eb});
    exp_q.push_back({28'd0, er});
    exp_q.push_back(ev);
    e = exp_q.pop_front(); check_eq({nm, "_busy"}, {31'd0, obusy}, e);
    e = exp_q.pop_front(); if (rob_known) check_eq({nm, "_rob_pos"}, {28'd0, orob}, e);
    e = exp_q.pop_front(); check_eq({nm, "_val"}, oval, e);
  endtask

  task automatic check_reads();
    #1;
    check_port("rs1", rs1_pos, rs1_busy, rs1_rob_pos, rs1_val);
    check_port("rs2", rs2_pos, rs2_busy, rs2_rob_pos, rs2_val);
  endtask

  task automatic advance();
    model_next();
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else for (int i = 0; i < 32; i++) begin
      m_val[i] = n_val[i]; m_busy[i] = n_busy[i]; m_tag[i] = n_tag[i];
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic rb,
                       input logic ie, input logic [4:0] ird, input logic [3:0] irob,
                       input logic ce, input logic [4:0] creg, input logic [31:0] cval,
                       input logic [3:0] crob, input logic [4:0] r1, input logic [4:0] r2);
    rdy = r; rollback = rb;
    issue_enable = ie; issue_rd = ird; issue_rob_pos = irob;
    commit_enable = ce; commit_reg_pos = creg; commit_val = cval; commit_rob_pos = crob;
    rs1_pos = r1; rs2_pos = r2;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    drive(1'($urandom), 1'($urandom), 1'b1, 5'd3, 4'd5, 1'b1, 5'd3, $urandom, 4'd5, 0, 0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // T1: all registers clear after reset
    for (int i = 0; i < 32; i++) begin
      idle(5'(i), 5'(31 - i));
      check_reads();
      check_eq("t1_busy", {31'd0, rs1_busy}, 0);
      check_eq("t1_val", rs1_val, 0);
    end

    // T2: issue then matching commit with bypass
    drive(1, 0, 1, 5, 3, 0, 0, 0, 0, 5, 0); check_reads(); advance();
    idle(5, 0); check_reads();
    check_eq("t2_busy", {31'd0, rs1_busy}, 1);
    check_eq("t2_rob", {28'd0, rs1_rob_pos}, 3);
    drive(1, 0, 0, 0, 0, 1, 5, 32'hDEAD, 3, 5, 0); check_reads();
    check_eq("t2_byp_busy", {31'd0, rs1_busy}, 0);
    check_eq("t2_byp_val", rs1_val, 32'hDEAD);
    advance();
    idle(5, 0); check_reads();
    check_eq("t2_st_busy", {31'd0, rs1_busy}, 0);
    check_eq("t2_st_val", rs1_val, 32'hDEAD);

    // T3: stale-tag commit keeps the newer rename
    drive(1, 0, 1, 5, 3, 0, 0, 0, 0, 5, 0); check_reads(); advance();
    drive(1, 0, 1, 5, 7, 0, 0, 0, 0, 5, 0); check_reads(); advance();
    drive(1, 0, 0, 0, 0, 1, 5, 1, 3, 5, 0); check_reads(); advance();
    idle(5, 0); check_reads();
    check_eq("t3_busy", {31'd0, rs1_busy}, 1);
    check_eq("t3_rob", {28'd0, rs1_rob_pos}, 7);
    check_eq("t3_valstate", dut.val_q[5], 1);

    // T4: same-cycle issue and commit on x6
    drive(1, 0, 1, 6, 2, 0, 0, 0, 0, 6, 0); check_reads(); advance();
    drive(1, 0, 1, 6, 9, 1, 6, 32'h55, 2, 6, 0); check_reads();
    check_eq("t4_byp_busy", {31'd0, rs1_busy}, 0);
    check_eq("t4_byp_val", rs1_val, 32'h55);
    advance();
    idle(6, 0); check_reads();
    check_eq("t4_busy", {31'd0, rs1_busy}, 1);
    check_eq("t4_rob", {28'd0, rs1_rob_pos}, 9);
    check_eq("t4_valstate", dut.val_q[6], 32'h55);

    // T5: x0 writes ignored, then rollback
    drive(1, 0, 1, 0, 4, 1, 0, 5, 4, 0, 0); check_reads();
    check_eq("t5_x0_val", rs1_val, 0);
    advance();
    idle(0, 0); check_reads();
    check_eq("t5_x0_busy", {31'd0, rs1_busy}, 0);
    check_eq("t5_x0_val2", rs1_val, 0);
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 1, 5'(i), 4'(i), 0, 0, 0, 0, 5'(i), 0); check_reads(); advance();
    end
    drive(1, 1, 1, 7, 8, 0, 0, 0, 0, 1, 7); check_reads(); advance();
    for (int i = 1; i <= 7; i++) begin
      idle(5'(i), 0); check_reads();
      check_eq("t5_rb_busy", {31'd0, rs1_busy}, 0);
    end

    // T6: rdy low freezes state
    drive(0, 0, 1, 8, 5, 1, 9, 32'h99, 0, 8, 9); check_reads(); advance();
    idle(8, 9); check_reads();
    check_eq("t6_x8_busy", {31'd0, rs1_busy}, 0);
    check_eq("t6_x9_val", rs2_val, 0);

    // Random traffic, register indices concentrated to force collisions
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] creg;
      logic [3:0] crob;
      creg = 5'($urandom_range(0, 9));
      crob = ($urandom_range(0, 3) != 0) ? m_tag[creg] : 4'($urandom);
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 24) == 0),
            1'($urandom), 5'($urandom_range(0, 9)), 4'($urandom),
            1'($urandom), creg, $urandom, crob,
            5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)));
      rst = ($urandom_range(0, 999) == 0);
      check_reads();
      advance();
      rst = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
